// File: rtl/rs485_pkg.sv
// ---------------------------------------------------------------------------
// rs485_pkg
// Shared definitions for the RS-485 receive path: frame delimiter, bit-run
// limits, default block widths, receive sequencer state encoding and a
// saturating counter helper.
// ---------------------------------------------------------------------------
package rs485_pkg;

    localparam logic [7:0] FLAG_PAT  = 8'h7E;
    // The transmitter inserts a zero after this many consecutive ones.
    localparam int         STUFF_RUN = 5;
    // Two ones beyond the stuffing limit can only be an abort sequence.
    localparam int         ABORT_RUN = STUFF_RUN + 2;
    localparam int         IN_W_DEF  = 48;
    localparam int         OUT_W_DEF = 40;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } rx_state_e;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/destuff_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// destuff_rx_ctrl_if
// valid/ready hand-off of destuffed blocks to the frame layer.
//   blk_data   destuffed block      (master -> slave)
//   blk_valid  blk_data valid       (master -> slave)
//   blk_ready  slave accepts block  (slave  -> master)
// ---------------------------------------------------------------------------
interface destuff_rx_ctrl_if
    import rs485_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
);
    logic [OUT_W-1:0] blk_data;
    logic             blk_valid;
    logic             blk_ready;

    modport master (output blk_data, output blk_valid, input  blk_ready);
    modport slave  (input  blk_data, input  blk_valid, output blk_ready);
endinterface

// File: rtl/rs485_flag_det.sv
// ---------------------------------------------------------------------------
// rs485_flag_det
// Tracks the last eight received bits and the current run of ones.
//   clk, rst      clock, asynchronous active-high reset
//   bit_i         received line bit
//   bit_vld_i     bit_i strobe
//   flag_hit_o    this bit completes the flag pattern (combinational)
//   abort_hit_o   this bit makes the ones-run reach ABORT_RUN (combinational)
// Both hits are qualified with bit_vld_i and include the current bit.
// ---------------------------------------------------------------------------
module rs485_flag_det
    import rs485_pkg::*;
#(
    parameter logic [7:0] FLAG = FLAG_PAT
)(
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic bit_vld_i,
    output logic flag_hit_o,
    output logic abort_hit_o
);
    logic [7:0] hist_q, hist_d;
    logic [2:0] ones_q, ones_d;

    // Next history and ones-run; the run saturates so long idle-ones lines
    // do not wrap back into a fresh abort.
    always_comb begin
        hist_d = hist_q;
        ones_d = ones_q;
        if (bit_vld_i) begin
            hist_d = {hist_q[6:0], bit_i};
            if (bit_i) begin
                if (ones_q != 3'd7) begin
                    ones_d = ones_q + 3'd1;
                end else begin
                    ones_d = ones_q;
                end
            end else begin
                ones_d = 3'd0;
            end
        end else begin
            hist_d = hist_q;
            ones_d = ones_q;
        end
    end

    // History and ones-run registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 8'd0;
            ones_q <= 3'd0;
        end else begin
            hist_q <= hist_d;
            ones_q <= ones_d;
        end
    end

    assign flag_hit_o  = bit_vld_i && (hist_d == FLAG);
    assign abort_hit_o = bit_vld_i && bit_i && (ones_q == 3'(ABORT_RUN - 1));

endmodule

// File: rtl/destuff_rx_ctrl.sv
// ---------------------------------------------------------------------------
// destuff_rx_ctrl
// Receive sequencer for the 48->40 bit-destuff engine. Hunts for the flag,
// packs line bits MSB-first into IN_W-bit stuffed blocks, drives each block to
// the external engine, waits DZ_LAT cycles and presents the OUT_W-bit result
// to the frame layer over valid/ready.
//   clk, rst      clock, asynchronous active-high reset
//   bit_in        received line bit, bit_vld its strobe
//   dz_data_in    stuffed block to engine (held stable while waiting)
//   dz_out_data   destuffed result from engine
//   blk_if        master side of blk_data/blk_valid/blk_ready
//   frame_end     pulse: flag right after a block boundary
//   frame_err     pulse: flag mid-block, partial block dropped
//   abort         pulse: seven consecutive ones
//   overrun       pulse: bit arrived while a block was in flight
//   busy          state is not HUNT
// Optional build macro DZ_STATS_EN adds frm_cnt / err_cnt event counters.
// ---------------------------------------------------------------------------
module destuff_rx_ctrl
    import rs485_pkg::*;
#(
    parameter int         IN_W   = IN_W_DEF,
    parameter int         OUT_W  = OUT_W_DEF,
    parameter int         DZ_LAT = 1,
    parameter logic [7:0] FLAG   = FLAG_PAT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic [IN_W-1:0]   dz_data_in,
    input  logic [OUT_W-1:0]  dz_out_data,
    destuff_rx_ctrl_if.master blk_if,
    output logic              frame_end,
    output logic              frame_err,
    output logic              abort,
    output logic              overrun,
    output logic              busy
`ifdef DZ_STATS_EN
    ,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       err_cnt
`endif
);
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int WAIT_W = (DZ_LAT < 2) ? 1 : $clog2(DZ_LAT + 1);

    rx_state_e           state_q, state_d;
    logic [IN_W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc_s;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [IN_W-1:0]     dz_q, dz_d;
    logic [OUT_W-1:0]    blk_data_q, blk_data_d;
    logic                blk_valid_q, blk_valid_d;
    logic                ovr_q, ovr_d;
    logic                frame_end_q, frame_end_d;
    logic                frame_err_q, frame_err_d;
    logic                abort_q, abort_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;
    logic                flag_hit_s, abort_hit_s, handshake_s, blk_done_s;

    rs485_flag_det #(.FLAG(FLAG)) u_flag_det (
        .clk         (clk),
        .rst         (rst),
        .bit_i       (bit_in),
        .bit_vld_i   (bit_vld),
        .flag_hit_o  (flag_hit_s),
        .abort_hit_o (abort_hit_s)
    );

    // cnt counts every bit since the last boundary, so a flag that directly
    // follows a boundary completes with cnt_inc_s == 8.
    assign cnt_inc_s   = cnt_q + CNT_W'(1);
    assign blk_done_s  = bit_vld && (cnt_inc_s == CNT_W'(IN_W));
    assign handshake_s = blk_valid_q && blk_if.blk_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort beats flag beats block-complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (flag_hit_s) state_d = COLLECT;
                else            state_d = HUNT;
            end
            COLLECT: begin
                if (abort_hit_s)     state_d = HUNT;
                else if (flag_hit_s) state_d = COLLECT;
                else if (blk_done_s) state_d = WAIT;
                else                 state_d = COLLECT;
            end
            WAIT: begin
                if (wait_q == '0) state_d = PRESENT;
                else              state_d = WAIT;
            end
            PRESENT: begin
                // A bit dropped in the handshake cycle itself also counts.
                if (handshake_s) state_d = (ovr_q || bit_vld) ? HUNT : COLLECT;
                else             state_d = PRESENT;
            end
            default: state_d = HUNT;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        dz_d        = dz_q;
        blk_data_d  = blk_data_q;
        blk_valid_d = blk_valid_q;
        ovr_d       = ovr_q;
        frame_end_d = 1'b0;
        frame_err_d = 1'b0;
        abort_d     = 1'b0;
        overrun_d   = 1'b0;
        busy_d      = (state_d != HUNT);
        case (state_q)
            HUNT: begin
                ovr_d = 1'b0;
                if (flag_hit_s) cnt_d = '0;
                else            cnt_d = cnt_q;
            end
            COLLECT: begin
                if (abort_hit_s) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (flag_hit_s) begin
                    cnt_d = '0;
                    if (cnt_inc_s == CNT_W'(8)) frame_end_d = 1'b1;
                    else                        frame_err_d = 1'b1;
                end else if (bit_vld) begin
                    shift_d = {shift_q[IN_W-2:0], bit_in};
                    if (blk_done_s) begin
                        dz_d   = {shift_q[IN_W-2:0], bit_in};
                        wait_d = WAIT_W'(DZ_LAT);
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            WAIT: begin
                if (bit_vld) begin
                    overrun_d = 1'b1;
                    ovr_d     = 1'b1;
                end else begin
                    overrun_d = 1'b0;
                end
                if (wait_q == '0) begin
                    blk_data_d  = dz_out_data;
                    blk_valid_d = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            PRESENT: begin
                if (bit_vld) begin
                    overrun_d = 1'b1;
                    ovr_d     = 1'b1;
                end else begin
                    overrun_d = 1'b0;
                end
                if (handshake_s) begin
                    blk_valid_d = 1'b0;
                    cnt_d       = '0;
                    ovr_d       = 1'b0;
                end else begin
                    blk_valid_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            dz_q        <= '0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            frame_end_q <= 1'b0;
            frame_err_q <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            dz_q        <= dz_d;
            blk_data_q  <= blk_data_d;
            blk_valid_q <= blk_valid_d;
            ovr_q       <= ovr_d;
            frame_end_q <= frame_end_d;
            frame_err_q <= frame_err_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign dz_data_in       = dz_q;
    assign blk_if.blk_data  = blk_data_q;
    assign blk_if.blk_valid = blk_valid_q;
    assign frame_end        = frame_end_q;
    assign frame_err        = frame_err_q;
    assign abort            = abort_q;
    assign overrun          = overrun_q;
    assign busy             = busy_q;

`ifdef DZ_STATS_EN
    logic [15:0] frm_cnt_q, err_cnt_q;

    // Event counters, one step per cycle with any event of the class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (frame_end_d) frm_cnt_q <= sat_inc16(frm_cnt_q);
            else             frm_cnt_q <= frm_cnt_q;
            if (frame_err_d || abort_d || overrun_d) err_cnt_q <= sat_inc16(err_cnt_q);
            else                                     err_cnt_q <= err_cnt_q;
        end
    end

    assign frm_cnt = frm_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_destuff_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_destuff_rx_ctrl
// Self-checking bench for destuff_rx_ctrl with a one-cycle destuff engine
// model. Expected blocks are queued as they are sent and popped on blk_valid.
// ---------------------------------------------------------------------------
module tb_destuff_rx_ctrl;
    import rs485_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic        bit_vld;
    logic [47:0] dz_data_in;
    logic [39:0] dz_out_data;
    logic        frame_end, frame_err, abort, overrun, busy;
`ifdef DZ_STATS_EN
    logic [15:0] frm_cnt, err_cnt;
`endif

    destuff_rx_ctrl_if #(.OUT_W(40)) blk_if ();

    destuff_rx_ctrl #(.IN_W(48), .OUT_W(40), .DZ_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .dz_data_in  (dz_data_in),
        .dz_out_data (dz_out_data),
        .blk_if      (blk_if),
        .frame_end   (frame_end),
        .frame_err   (frame_err),
        .abort       (abort),
        .overrun     (overrun),
        .busy        (busy)
`ifdef DZ_STATS_EN
        ,
        .frm_cnt     (frm_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference zero deletion: drop the 0 after five ones, keep first 40 bits.
    function automatic logic [39:0] destuff(input logic [47:0] blk);
        logic [39:0] o;
        int n;
        int ones;
        o = '0;
        n = 0;
        ones = 0;
        for (int i = 47; i >= 0; i--) begin
            if (ones == 5 && blk[i] == 1'b0) begin
                ones = 0;
            end else begin
                if (n < 40) begin
                    o = {o[38:0], blk[i]};
                    n++;
                end
                if (blk[i]) ones++;
                else        ones = 0;
            end
        end
        if (n < 40) o = o << (40 - n);
        return o;
    endfunction

    // Engine model, DZ_LAT = 1.
    always @(posedge clk or posedge rst) begin
        if (rst) dz_out_data <= '0;
        else     dz_out_data <= destuff(dz_data_in);
    end

    int n_vec = 0;
    int n_bad = 0;
    int n_fe = 0, n_fr = 0, n_ab = 0, n_ov = 0, n_blk = 0, n_errcyc = 0;
    int exp_fe = 0, exp_fr = 0, exp_ab = 0, exp_err = 0;
    logic bv_prev = 1'b0;
    logic [39:0] exp_q[$];
    logic [47:0] blk_q[$];

    // Event tallies sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            bv_prev <= 1'b0;
        end else begin
            if (frame_end) n_fe <= n_fe + 1;
            if (frame_err) n_fr <= n_fr + 1;
            if (abort)     n_ab <= n_ab + 1;
            if (overrun)   n_ov <= n_ov + 1;
            if (frame_err || abort || overrun) n_errcyc <= n_errcyc + 1;
            if (blk_if.blk_valid && !bv_prev) n_blk <= n_blk + 1;
            bv_prev <= blk_if.blk_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_vld = 1'b1;
        @(posedge clk); #1;
        bit_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_flag();
        send_bits(48'h7E, 8);
    endtask

    task automatic send_block(input logic [47:0] v);
        exp_q.push_back(destuff(v));
        blk_q.push_back(v);
        send_bits(v, 48);
    endtask

    // Waits for blk_valid right after a block's last bit; ready assumed high.
    task automatic wait_block(input string nm);
        int cyc;
        logic [39:0] e;
        logic [47:0] eb;
        cyc = 0;
        while (blk_if.blk_valid !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (blk_if.blk_valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_valid: blk_valid=%b queued=%0d, required valid with a queued block",
                     nm, blk_if.blk_valid, exp_q.size());
        end else begin
            e  = exp_q.pop_front();
            eb = blk_q.pop_front();
            n_vec++;
            if (cyc !== 2) begin
                n_bad++;
                $display("FAIL %s_latency: got %0d cycles, required 2", nm, cyc);
            end
            n_vec++;
            if (blk_if.blk_data !== e) begin
                n_bad++;
                $display("FAIL %s_data: got %h, required %h", nm, blk_if.blk_data, e);
            end
            n_vec++;
            if (dz_data_in !== eb) begin
                n_bad++;
                $display("FAIL %s_dz: got %h, required %h", nm, dz_data_in, eb);
            end
            @(posedge clk); #1;
            n_vec++;
            if (blk_if.blk_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_release: blk_valid=%b, required 0", nm, blk_if.blk_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bit_in = 1'b0;
        bit_vld = 1'b0;
        blk_if.blk_ready = 1'b1;
        idle(3);
        n_vec++;
        if ({frame_end, frame_err, abort, overrun, busy, blk_if.blk_valid} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {frame_end, frame_err, abort, overrun, busy, blk_if.blk_valid});
        end
        n_vec++;
        if (blk_if.blk_data !== 40'h0 || dz_data_in !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_data: blk_data=%h dz=%h, required 0", blk_if.blk_data, dz_data_in);
        end
        rst = 1'b0;
        idle(2);
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
    endtask

    task automatic check_events(input string nm);
        idle(2);
        n_vec++;
        if (n_fe !== exp_fe || n_fr !== exp_fr || n_ab !== exp_ab) begin
            n_bad++;
            $display("FAIL %s_events: fe/fr/ab=%0d/%0d/%0d, required %0d/%0d/%0d",
                     nm, n_fe, n_fr, n_ab, exp_fe, exp_fr, exp_ab);
        end
    endtask

    task automatic test_clean_block();
        send_flag();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_busy: got %b, required 1", busy);
        end
        send_block(48'hA5A5A5A5A5A5);
        wait_block("clean");
        send_flag();
        exp_fe++;
        check_events("clean");
    endtask

    task automatic test_stuffed();
        send_block(48'hF8A5A5A5A5A5);
        wait_block("stuff_f8");
        send_block(48'h3E3E3E3E3E3E);
        wait_block("stuff_3e");
        send_flag();
        exp_fe++;
        check_events("stuffed");
    endtask

    task automatic test_frame_err();
        int b0;
        b0 = n_blk;
        send_bits(48'hA5A5A, 20);
        send_flag();
        exp_fr++;
        exp_err++;
        check_events("ferr");
        n_vec++;
        if (n_blk !== b0) begin
            n_bad++;
            $display("FAIL ferr_noblk: blocks=%0d, required %0d", n_blk, b0);
        end
        send_block(48'h5A5A5A5A5A5A);
        wait_block("ferr_next");
        send_flag();
        exp_fe++;
        check_events("ferr_close");
    endtask

    task automatic test_abort();
        int b0;
        send_flag();
        exp_fe++;
        send_bits(48'h7F, 7);
        exp_ab++;
        exp_err++;
        check_events("abort");
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_busy: got %b, required 0", busy);
        end
        b0 = n_blk;
        send_bits(48'hA5A5A5A5A5A5, 48);
        idle(4);
        n_vec++;
        if (n_blk !== b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ignore: blocks=%0d busy=%b, required %0d and 0", n_blk, busy, b0);
        end
        check_events("abort_hunt");
        send_flag();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_rehunt: busy=%b, required 1", busy);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        logic got;
        logic [39:0] snap;
        logic [39:0] e;
        logic [47:0] eb;
        got = 1'b0;
        snap = '0;
        blk_if.blk_ready = 1'b0;
        send_block(48'hA5A5A5A5A5A5);
        ov0 = n_ov;
        for (int i = 0; i < 10; i++) begin
            send_bit(i[0]);
            if (blk_if.blk_valid === 1'b1 && !got) begin
                got = 1'b1;
                snap = blk_if.blk_data;
            end
        end
        idle(2);
        exp_err += 10;
        e  = exp_q.pop_front();
        eb = blk_q.pop_front();
        n_vec++;
        if (n_ov - ov0 !== 10) begin
            n_bad++;
            $display("FAIL ovr_pulses: got %0d, required 10", n_ov - ov0);
        end
        n_vec++;
        if (blk_if.blk_valid !== 1'b1 || blk_if.blk_data !== e || snap !== e) begin
            n_bad++;
            $display("FAIL ovr_hold: valid=%b data=%h early=%h, required 1 %h %h",
                     blk_if.blk_valid, blk_if.blk_data, snap, e, e);
        end
        n_vec++;
        if (dz_data_in !== eb) begin
            n_bad++;
            $display("FAIL ovr_dz: got %h, required %h", dz_data_in, eb);
        end
        blk_if.blk_ready = 1'b1;
        idle(1);
        n_vec++;
        if (blk_if.blk_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_hunt: valid=%b busy=%b, required 0 0", blk_if.blk_valid, busy);
        end
        check_events("ovr");
    endtask

    task automatic test_stats();
`ifdef DZ_STATS_EN
        n_vec++;
        if (frm_cnt !== 16'(exp_fe) || err_cnt !== 16'(exp_err)) begin
            n_bad++;
            $display("FAIL stats: frm=%0d err=%0d, required %0d %0d", frm_cnt, err_cnt, exp_fe, exp_err);
        end
`endif
        n_vec++;
        if (n_errcyc !== exp_err) begin
            n_bad++;
            $display("FAIL err_events: got %0d, required %0d", n_errcyc, exp_err);
        end
    endtask

    task automatic test_reset_in_wait();
        int b0;
        send_flag();
        send_bits(48'h5A5A5A5A5A5A, 48);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstw_busy: got %b, required 1", busy);
        end
        b0 = n_blk;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, blk_if.blk_valid, frame_end, frame_err, abort, overrun} !== 6'b0
            || dz_data_in !== 48'h0) begin
            n_bad++;
            $display("FAIL rstw_clear: flags=%b dz=%h, required 0",
                     {busy, blk_if.blk_valid, frame_end, frame_err, abort, overrun}, dz_data_in);
        end
`ifdef DZ_STATS_EN
        n_vec++;
        if (frm_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL rstw_stats: frm=%0d err=%0d, required 0", frm_cnt, err_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);
        n_vec++;
        if (n_blk !== b0 || blk_if.blk_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstw_lost: blocks=%0d valid=%b busy=%b, required %0d 0 0",
                     n_blk, blk_if.blk_valid, busy, b0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_block();
        test_stuffed();
        test_frame_err();
        test_abort();
        test_overrun();
        test_stats();
        test_reset_in_wait();
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d blocks left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
